ddr4_cmd_sequencer: RTL

Parametrised DDR4 command/address front end that drives the CA pins of the DDR4 device bundle (`ACT_n`, `RAS_n_A16`, `CAS_n_A15`, `WE_n_A14`, `CS_n`, `BG`, `BA`, `ADDR`, `ADDR_17`, `PARITY`) from a queued command stream. It generalises the fixed x8 single-rank pin set to x4/x8/x16 and multiple ranks. It also adds per-bank open-row tracking and minimum-spacing enforcement (tRCD, tRP, tCCD, tRFC). It sits between the stimulus/controller logic and the DDR4 model interface.

---
 rtl/ddr4_cmd_sequencer_if.sv | 29 ++
 rtl/ddr4_cmd_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_cmd_sequencer_if.sv
// Command-side handshake bundle for ddr4_cmd_sequencer.
// The master offers commands and the slave reports queue space.
interface ddr4_cmd_sequencer_if #(
    parameter int DQ_BITS   = 8,
    parameter int RANK_BITS = 1,
    parameter int BANK_BITS = 2
);
    localparam int BG_BITS = (DQ_BITS == 16) ? 1 : 2;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2:0]           cmd_op;
    logic [RANK_BITS-1:0] cmd_rank;
    logic [BG_BITS-1:0]   cmd_bg;
    logic [BANK_BITS-1:0] cmd_ba;
    logic [17:0]          cmd_addr;

    modport master (
        output cmd_valid, cmd_op, cmd_rank,
        output cmd_bg, cmd_ba, cmd_addr,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rank,
        input  cmd_bg, cmd_ba, cmd_addr,
        output cmd_ready
    );
endinterface

// File: rtl/ddr4_cmd_sequencer.sv
// DDR4 CA-pin sequencer: queued commands, bank tracking, tRCD/tRP/tCCD/tRFC.
// Optional CA parity generation is enabled by defining DDR4_CA_PARITY_EN.
module ddr4_cmd_sequencer #(
    parameter int DQ_BITS    = 8,
    parameter int RANK_BITS  = 1,
    parameter int BANK_BITS  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int T_RCD      = 4,
    parameter int T_RP       = 4,
    parameter int T_CCD      = 4,
    parameter int T_RFC      = 32,
    localparam int BG_BITS   = (DQ_BITS == 16) ? 1 : 2
) (
    input  logic                        clk,
    input  logic                        rst,
    ddr4_cmd_sequencer_if.slave         cmd,
    output logic                        ACT_n,
    output logic                        RAS_n_A16,
    output logic                        CAS_n_A15,
    output logic                        WE_n_A14,
    output logic [(1<<RANK_BITS)-1:0]   CS_n,
    output logic [BG_BITS-1:0]          BG,
    output logic [BANK_BITS-1:0]        BA,
    output logic [13:0]                 ADDR,
    output logic                        ADDR_17,
    output logic                        PARITY,
    output logic                        err,
    output logic                        busy
);
    localparam int NR   = 1 << RANK_BITS;
    localparam int BKW  = BG_BITS + BANK_BITS;
    localparam int BPR  = 1 << BKW;
    localparam int IW   = RANK_BITS + BKW;
    localparam int NB   = 1 << IW;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int TM1  = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int TM2  = (T_CCD > T_RFC) ? T_CCD : T_RFC;
    localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        OP_NOP, OP_ACT, OP_RD, OP_WR,
        OP_PRE, OP_PREA, OP_REF, OP_MRS
    } op_e;

    typedef struct packed {
        op_e                  op;
        logic [RANK_BITS-1:0] rank;
        logic [BG_BITS-1:0]   bg;
        logic [BANK_BITS-1:0] ba;
        logic [17:0]          addr;
    } ent_t;

    ent_t          mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0]   count;
    ent_t          head;
    logic          push, pop, full;

    logic [NB-1:0] open;
    logic [CW-1:0] trcd_cnt [NB];
    logic [CW-1:0] trp_cnt [NB];
    logic [CW-1:0] trfc_cnt [NR];
    logic [CW-1:0] tccd_cnt;

    logic [IW-1:0] hidx;
    logic          issue, bad, rk_open, rk_trp, rfc_ok;
    logic          e_act, e_ras, e_cas, e_we, e_a17;
    logic [13:0]   e_addr;

    function automatic logic [CW-1:0] dec(input logic [CW-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    assign head  = mem[rptr];
    assign hidx  = {head.rank, head.bg, head.ba};
    assign full  = (count == (PW+1)'(FIFO_DEPTH));
    assign pop   = issue || bad;
    assign push  = cmd.cmd_valid && cmd.cmd_ready
                && (op_e'(cmd.cmd_op) != OP_NOP);
    // A full queue still accepts when the head leaves this cycle.
    assign cmd.cmd_ready = !full || pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= '{op:   op_e'(cmd.cmd_op),
                           rank: cmd.cmd_rank,
                           bg:   cmd.cmd_bg,
                           ba:   cmd.cmd_ba,
                           addr: cmd.cmd_addr};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        issue   = 1'b0;
        bad     = 1'b0;
        rk_open = 1'b0;
        rk_trp  = 1'b0;
        for (int j = 0; j < BPR; j++) begin
            rk_open |= open[{head.rank, BKW'(j)}];
            rk_trp  |= (trp_cnt[{head.rank, BKW'(j)}] != '0);
        end
        rfc_ok = (trfc_cnt[head.rank] == '0);
        if (count != '0) begin
            unique case (head.op)
                OP_ACT: begin
                    bad   = open[hidx];
                    issue = !open[hidx] && rfc_ok
                         && (trp_cnt[hidx] == '0);
                end
                OP_RD, OP_WR: begin
                    bad   = !open[hidx];
                    issue = open[hidx]
                         && (trcd_cnt[hidx] == '0)
                         && (tccd_cnt == '0);
                end
                OP_PRE, OP_PREA: issue = rfc_ok;
                OP_REF: begin
                    bad   = rk_open;
                    issue = !rk_open && rfc_ok && !rk_trp;
                end
                OP_MRS: begin
                    bad   = rk_open;
                    issue = !rk_open && rfc_ok;
                end
                default: bad = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                trcd_cnt[i] <= '0;
                trp_cnt[i]  <= '0;
            end
            for (int r = 0; r < NR; r++) trfc_cnt[r] <= '0;
            tccd_cnt <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                trcd_cnt[i] <= dec(trcd_cnt[i]);
                trp_cnt[i]  <= dec(trp_cnt[i]);
            end
            for (int r = 0; r < NR; r++) begin
                trfc_cnt[r] <= dec(trfc_cnt[r]);
            end
            tccd_cnt <= dec(tccd_cnt);
            if (issue) begin
                unique case (head.op)
                    OP_ACT: trcd_cnt[hidx] <= CW'(T_RCD - 1);
                    OP_RD, OP_WR: tccd_cnt <= CW'(T_CCD - 1);
                    OP_PRE: trp_cnt[hidx] <= CW'(T_RP - 1);
                    OP_PREA: begin
                        for (int j = 0; j < BPR; j++) begin
                            trp_cnt[{head.rank, BKW'(j)}]
                                <= CW'(T_RP - 1);
                        end
                    end
                    OP_REF: trfc_cnt[head.rank] <= CW'(T_RFC - 1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open <= '0;
        end else if (issue) begin
            unique case (head.op)
                OP_ACT: open[hidx] <= 1'b1;
                OP_PRE: open[hidx] <= 1'b0;
                OP_PREA: begin
                    for (int j = 0; j < BPR; j++) begin
                        open[{head.rank, BKW'(j)}] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (count != '0) || (tccd_cnt != '0);
        for (int i = 0; i < NB; i++) begin
            busy |= (trcd_cnt[i] != '0) || (trp_cnt[i] != '0);
        end
        for (int r = 0; r < NR; r++) begin
            busy |= (trfc_cnt[r] != '0);
        end
    end

    always_comb begin
        e_act  = 1'b1;
        {e_ras, e_cas, e_we} = 3'b111;
        e_addr = head.addr[13:0];
        e_a17  = head.addr[17];
        unique case (head.op)
            OP_ACT: begin
                e_act = 1'b0;
                {e_ras, e_cas, e_we} = head.addr[16:14];
            end
            OP_MRS: {e_ras, e_cas, e_we} = 3'b000;
            OP_REF: begin
                {e_ras, e_cas, e_we} = 3'b001;
                e_addr[10] = 1'b0;
            end
            OP_PRE: begin
                {e_ras, e_cas, e_we} = 3'b010;
                e_addr[10] = 1'b0;
            end
            OP_PREA: begin
                {e_ras, e_cas, e_we} = 3'b010;
                e_addr = 14'h0400;
            end
            OP_WR, OP_RD: begin
                {e_ras, e_cas, e_we} = {2'b10, head.op == OP_RD};
                e_addr[10] = 1'b0;
                e_addr[12] = 1'b1;
            end
            default: e_act = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CS_n      <= '1;
            ACT_n     <= 1'b1;
            RAS_n_A16 <= 1'b1;
            CAS_n_A15 <= 1'b1;
            WE_n_A14  <= 1'b1;
            BG        <= '0;
            BA        <= '0;
            ADDR      <= '0;
            ADDR_17   <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= bad;
            if (issue) begin
                CS_n      <= ~(NR'(1) << head.rank);
                ACT_n     <= e_act;
                RAS_n_A16 <= e_ras;
                CAS_n_A15 <= e_cas;
                WE_n_A14  <= e_we;
                BG        <= head.bg;
                BA        <= head.ba;
                ADDR      <= e_addr;
                ADDR_17   <= e_a17;
            end else begin
                CS_n      <= '1;
                ACT_n     <= 1'b1;
                RAS_n_A16 <= 1'b1;
                CAS_n_A15 <= 1'b1;
                WE_n_A14  <= 1'b1;
            end
        end
    end

`ifdef DDR4_CA_PARITY_EN
    // Even parity: the pins plus PARITY carry an even count of ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PARITY <= 1'b0;
        end else if (issue) begin
            PARITY <= ^{e_act, e_ras, e_cas, e_we,
                        head.bg, head.ba, e_addr, e_a17};
        end
    end
`else
    assign PARITY = 1'b0;
`endif
endmodule
